// File: rtl/grid_actor_ctrl.sv
// rtl/grid_actor_ctrl.sv - grid-walking actor: tile position, pixel-step animation, facing/frame, HP
// Optional post-hit invulnerability window enabled with `define ACTOR_INVULN_EN.
module grid_actor_ctrl #(
  parameter int TILE_LOG      = 5,
  parameter int WALK_DELAY    = 5,
  parameter int START_R       = 3,
  parameter int START_C       = 3,
  parameter int HP_W          = 5,
  parameter int HP_FULL       = 5,
  parameter int N_MON         = 2,
  parameter int DAMAGE        = 1,
  parameter int INVULN_CYCLES = 1024
) (
  input  logic                  clk_13,
  input  logic                  rst,
  input  logic                  up_pressed,
  input  logic                  down_pressed,
  input  logic                  left_pressed,
  input  logic                  right_pressed,
  input  logic [2:0]            dest_type,
  output logic [9:0]            dest_r,
  output logic [9:0]            dest_c,
  output logic [9:0]            actor_r,
  output logic [9:0]            actor_c,
  output logic [9:0]            actor_v,
  output logic [9:0]            actor_h,
  output logic [2:0]            facing,
  output logic [1:0]            frame,
  output logic                  moving,
  input  logic [10*N_MON-1:0]   mon_r,
  input  logic [10*N_MON-1:0]   mon_c,
  input  logic [N_MON-1:0]      mon_alive,
  output logic [HP_W-1:0]       hp,
  output logic                  alive,
  output logic                  hit,
  output logic                  invuln
);

  localparam logic [2:0] ST_STOP  = 3'd0;
  localparam logic [2:0] ST_DOWN  = 3'd1;
  localparam logic [2:0] ST_UP    = 3'd2;
  localparam logic [2:0] ST_LEFT  = 3'd3;
  localparam logic [2:0] ST_RIGHT = 3'd4;
  localparam int         DW       = HP_W + 4;
  localparam logic [9:0] START_V  = 10'(START_R) << TILE_LOG;
  localparam logic [9:0] START_H  = 10'(START_C) << TILE_LOG;

  logic [2:0]            state_q, state_d;
  logic [2:0]            facing_q, facing_d;
  logic [9:0]            actor_r_q, actor_r_d;
  logic [9:0]            actor_c_q, actor_c_d;
  logic [9:0]            actor_v_q, actor_v_d;
  logic [9:0]            actor_h_q, actor_h_d;
  logic [WALK_DELAY-1:0] sub_cnt_q, sub_cnt_d;
  logic [TILE_LOG-1:0]   pix_cnt_q, pix_cnt_d;
  logic [HP_W-1:0]       hp_q, hp_d;
  logic                  hit_q, hit_d;
  logic [10*N_MON-1:0]   mon_r_prev_q, mon_c_prev_q;

  logic [2:0]            key_dir;
  logic                  dest_ok;
  logic [DW-1:0]         qual_cnt;
  logic [DW-1:0]         dmg;
  logic [DW-1:0]         hp_ext;
  logic                  take_hit;
  logic                  invuln_w;

  assign alive = (hp_q != '0);

  always_comb begin
    key_dir = ST_STOP;
    if (up_pressed)         key_dir = ST_UP;
    else if (down_pressed)  key_dir = ST_DOWN;
    else if (left_pressed)  key_dir = ST_LEFT;
    else if (right_pressed) key_dir = ST_RIGHT;
  end

  // The map probe only looks ahead while idle and alive; otherwise it points at the actor itself.
  always_comb begin
    dest_r = actor_r_q;
    dest_c = actor_c_q;
    if (state_q == ST_STOP && alive) begin
      case (key_dir)
        ST_UP:    dest_r = actor_r_q - 10'd1;
        ST_DOWN:  dest_r = actor_r_q + 10'd1;
        ST_LEFT:  dest_c = actor_c_q - 10'd1;
        ST_RIGHT: dest_c = actor_c_q + 10'd1;
        default:  ;
      endcase
    end
  end

  assign dest_ok = (dest_type == 3'b000) || (dest_type == 3'b001) || (dest_type == 3'b011);

  always_comb begin
    qual_cnt = '0;
    for (int i = 0; i < N_MON; i++) begin
      if (mon_alive[i]
          && ({mon_r[10*i +: 10], mon_c[10*i +: 10]} != {mon_r_prev_q[10*i +: 10], mon_c_prev_q[10*i +: 10]})
          && ({mon_r[10*i +: 10], mon_c[10*i +: 10]} == {actor_r_q, actor_c_q}))
        qual_cnt = qual_cnt + DW'(1);
    end
  end

  assign dmg      = qual_cnt * DW'(DAMAGE);
  assign hp_ext   = DW'(hp_q);
  assign take_hit = alive && !invuln_w && (dmg != '0);

  always_comb begin
    state_d   = state_q;
    facing_d  = facing_q;
    actor_r_d = actor_r_q;
    actor_c_d = actor_c_q;
    actor_v_d = actor_v_q;
    actor_h_d = actor_h_q;
    sub_cnt_d = sub_cnt_q;
    pix_cnt_d = pix_cnt_q;
    hp_d      = hp_q;
    hit_d     = 1'b0;

    if (!alive) begin
      state_d = ST_STOP;
    end else if (state_q == ST_STOP) begin
      if (key_dir != ST_STOP) begin
        facing_d = key_dir;
        if (dest_ok) begin
          actor_r_d = dest_r;
          actor_c_d = dest_c;
          state_d   = key_dir;
          sub_cnt_d = '0;
          pix_cnt_d = '0;
        end
      end
    end else begin
      sub_cnt_d = sub_cnt_q + 1'b1;
      if (&sub_cnt_q) begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        case (state_q)
          ST_DOWN:  actor_v_d = actor_v_q + 10'd1;
          ST_UP:    actor_v_d = actor_v_q - 10'd1;
          ST_LEFT:  actor_h_d = actor_h_q - 10'd1;
          default:  actor_h_d = actor_h_q + 10'd1;
        endcase
        if (&pix_cnt_q) state_d = ST_STOP;
      end
    end

    if (take_hit) begin
      hp_d  = (dmg >= hp_ext) ? '0 : HP_W'(hp_ext - dmg);
      hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk_13) begin
    if (!rst) begin
      state_q      <= ST_STOP;
      facing_q     <= ST_DOWN;
      actor_r_q    <= 10'(START_R);
      actor_c_q    <= 10'(START_C);
      actor_v_q    <= START_V;
      actor_h_q    <= START_H;
      sub_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      hp_q         <= HP_W'(HP_FULL);
      hit_q        <= 1'b0;
      mon_r_prev_q <= mon_r;
      mon_c_prev_q <= mon_c;
    end else begin
      state_q      <= state_d;
      facing_q     <= facing_d;
      actor_r_q    <= actor_r_d;
      actor_c_q    <= actor_c_d;
      actor_v_q    <= actor_v_d;
      actor_h_q    <= actor_h_d;
      sub_cnt_q    <= sub_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      hp_q         <= hp_d;
      hit_q        <= hit_d;
      mon_r_prev_q <= mon_r;
      mon_c_prev_q <= mon_c;
    end
  end

`ifdef ACTOR_INVULN_EN
  logic        invuln_q, invuln_d;
  logic [15:0] invuln_cnt_q, invuln_cnt_d;

  // Damage arriving inside the window is dropped, never deferred.
  always_comb begin
    invuln_d     = invuln_q;
    invuln_cnt_d = invuln_cnt_q;
    if (take_hit) begin
      invuln_d     = 1'b1;
      invuln_cnt_d = 16'(INVULN_CYCLES - 1);
    end else if (invuln_q) begin
      if (invuln_cnt_q == '0) invuln_d = 1'b0;
      else                    invuln_cnt_d = invuln_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_13) begin
    if (!rst) begin
      invuln_q     <= 1'b0;
      invuln_cnt_q <= '0;
    end else begin
      invuln_q     <= invuln_d;
      invuln_cnt_q <= invuln_cnt_d;
    end
  end

  assign invuln_w = invuln_q;
`else
  assign invuln_w = 1'b0;
`endif

  assign actor_r = actor_r_q;
  assign actor_c = actor_c_q;
  assign actor_v = actor_v_q;
  assign actor_h = actor_h_q;
  assign facing  = facing_q;
  assign moving  = (state_q != ST_STOP) && alive;
  assign frame   = !moving ? 2'd0 : (pix_cnt_q[TILE_LOG-1] ? 2'd2 : 2'd1);
  assign hp      = hp_q;
  assign hit     = hit_q;
  assign invuln  = invuln_w;

endmodule

// File: tb/tb_grid_actor_ctrl.sv
// tb/tb_grid_actor_ctrl.sv - directed self-checking bench for grid_actor_ctrl
module tb_grid_actor_ctrl;

  logic        clk_13 = 1'b0;
  logic        rst = 1'b0;
  logic        up_pressed = 1'b0, down_pressed = 1'b0, left_pressed = 1'b0, right_pressed = 1'b0;
  logic [2:0]  dest_type = 3'b000;
  logic [9:0]  dest_r, dest_c, actor_r, actor_c, actor_v, actor_h;
  logic [2:0]  facing;
  logic [1:0]  frame;
  logic        moving;
  logic [19:0] mon_r = '0, mon_c = '0;
  logic [1:0]  mon_alive = 2'b00;
  logic [4:0]  hp;
  logic        alive, hit, invuln;

  int errors = 0;
  int checks = 0;

  grid_actor_ctrl #(.INVULN_CYCLES(8)) dut (
    .clk_13(clk_13), .rst(rst),
    .up_pressed(up_pressed), .down_pressed(down_pressed),
    .left_pressed(left_pressed), .right_pressed(right_pressed),
    .dest_type(dest_type), .dest_r(dest_r), .dest_c(dest_c),
    .actor_r(actor_r), .actor_c(actor_c), .actor_v(actor_v), .actor_h(actor_h),
    .facing(facing), .frame(frame), .moving(moving),
    .mon_r(mon_r), .mon_c(mon_c), .mon_alive(mon_alive),
    .hp(hp), .alive(alive), .hit(hit), .invuln(invuln)
  );

  always #5 clk_13 = ~clk_13;

  task automatic tick;
    @(posedge clk_13);
    #1;
  endtask

  task automatic set_mon(input int i, input int r, input int c);
    mon_r[10*i +: 10] = 10'(r);
    mon_c[10*i +: 10] = 10'(c);
  endtask

  task automatic do_reset;
    up_pressed = 0; down_pressed = 0; left_pressed = 0; right_pressed = 0;
    dest_type = 3'b000;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    set_mon(0, 100, 100); set_mon(1, 200, 200); mon_alive = 2'b00;
    rst = 1'b0;
    tick();
    chk("reset_r", actor_r, 3);
    chk("reset_c", actor_c, 3);
    chk("reset_v", actor_v, 96);
    chk("reset_h", actor_h, 96);
    chk("reset_facing", facing, 1);
    chk("reset_frame", frame, 0);
    chk("reset_moving", moving, 0);
    chk("reset_hp", hp, 5);
    chk("reset_alive", alive, 1);
    chk("reset_hit", hit, 0);
    chk("reset_invuln", invuln, 0);
    rst = 1'b1;
  endtask

  task automatic test_walk_right;
    do_reset();
    right_pressed = 1; dest_type = 3'b000;
    #1;
    chk("walk_dest_r", dest_r, 3);
    chk("walk_dest_c", dest_c, 4);
    tick();
    right_pressed = 0;
    chk("walk_col", actor_c, 4);
    chk("walk_facing", facing, 4);
    for (int n = 0; n < 1024; n++) begin
      chk("walk_moving", moving, 1);
      chk("walk_h", actor_h, 96 + n / 32);
      chk("walk_frame", frame, (n < 512) ? 1 : 2);
      tick();
    end
    chk("walk_end_moving", moving, 0);
    chk("walk_end_h", actor_h, 128);
    chk("walk_end_frame", frame, 0);
    chk("walk_end_v", actor_v, 96);
  endtask

  task automatic test_blocked_priority;
    do_reset();
    up_pressed = 1; dest_type = 3'b010;
    #1;
    chk("blk_dest_r", dest_r, 2);
    chk("blk_dest_c", dest_c, 3);
    tick();
    up_pressed = 0;
    chk("blk_r", actor_r, 3);
    chk("blk_facing", facing, 2);
    chk("blk_moving", moving, 0);
    down_pressed = 1; left_pressed = 1;
    #1;
    chk("prio_dest_r", dest_r, 4);
    chk("prio_dest_c", dest_c, 3);
    tick();
    down_pressed = 0; left_pressed = 0;
    chk("prio_facing", facing, 1);
    chk("prio_r", actor_r, 3);
    dest_type = 3'b000;
  endtask

  task automatic test_damage;
    set_mon(0, 3, 2); set_mon(1, 3, 3); mon_alive = 2'b11;
    do_reset();
    tick(); tick();
    chk("dmg_static_hp", hp, 5);
    chk("dmg_static_hit", hit, 0);
    set_mon(0, 3, 3);
    tick();
    chk("dmg_hp", hp, 4);
    chk("dmg_hit", hit, 1);
    tick();
    chk("dmg_hit_pulse", hit, 0);
    chk("dmg_hp_hold", hp, 4);
  endtask

  task automatic test_death;
    set_mon(0, 3, 2); set_mon(1, 2, 3); mon_alive = 2'b11;
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      set_mon(0, 3, 3);
      tick();
      set_mon(0, 3, 2);
      repeat (12) tick();
    end
    chk("death_pre_hp", hp, 1);
    set_mon(0, 3, 3); set_mon(1, 3, 3);
    tick();
    chk("death_hp", hp, 0);
    chk("death_alive", alive, 0);
    chk("death_hit", hit, 1);
    right_pressed = 1; dest_type = 3'b000;
    #1;
    chk("death_dest_c", dest_c, 3);
    tick();
    right_pressed = 0;
    chk("death_c", actor_c, 3);
    chk("death_moving", moving, 0);
    set_mon(0, 3, 2); tick();
    set_mon(0, 3, 3); tick();
    chk("death_hp_stays", hp, 0);
  endtask

  task automatic test_invuln;
    int exp_hp;
    set_mon(0, 3, 2); set_mon(1, 2, 3); mon_alive = 2'b11;
    do_reset();
    tick();
    set_mon(0, 3, 3);
    tick();                       // E0
    chk("inv_first_hp", hp, 4);
`ifdef ACTOR_INVULN_EN
    chk("inv_set", invuln, 1);
`else
    chk("inv_set", invuln, 0);
`endif
    set_mon(0, 3, 2);
    tick(); tick(); tick();       // E1..E3
    set_mon(1, 3, 3);
    tick();                       // E4
`ifdef ACTOR_INVULN_EN
    exp_hp = 4;
`else
    exp_hp = 3;
`endif
    chk("inv_second_hp", hp, exp_hp);
    set_mon(1, 2, 3);
    tick(); tick(); tick(); tick(); // E5..E8
    chk("inv_cleared", invuln, 0);
    set_mon(0, 3, 3);
    tick();                       // E9
    chk("inv_third_hp", hp, exp_hp - 1);
    chk("inv_third_hit", hit, 1);
  endtask

  task automatic test_reset_mid_step;
    set_mon(0, 100, 100); set_mon(1, 200, 200); mon_alive = 2'b00;
    do_reset();
    left_pressed = 1; dest_type = 3'b000;
    tick();
    left_pressed = 0;
    chk("mid_col", actor_c, 2);
    repeat (500) tick();
    chk("mid_moving", moving, 1);
    chk("mid_h", actor_h, 81);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_r", actor_r, 3);
    chk("mid_rst_c", actor_c, 3);
    chk("mid_rst_h", actor_h, 96);
    chk("mid_rst_moving", moving, 0);
    chk("mid_rst_frame", frame, 0);
    chk("mid_rst_hp", hp, 5);
    tick();
    chk("mid_rst_stay_h", actor_h, 96);
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_blocked_priority();
    test_damage();
    test_death();
    test_invuln();
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_actor_ctrl.md
Name: grid_actor_ctrl

Overview:
Parametrised grid-walking actor controller, the next generation of the player block. It holds the actor's tile position, the smooth pixel-step animation, facing and walk-frame selection, and HP. HP takes damage from N_MON monster channels, with a post-hit invulnerability window. It outputs a sprite frame index and a VGA-space origin, not pixels, so the sprite ROM lookup lives in a shared renderer. It is used for the player and for future NPC actors.

Parameters:
TILE_LOG, 5, log2 of tile edge in VGA pixels (tile = 32)
WALK_DELAY, 5, log2 of clk_13 cycles per 1-pixel step
START_R, 3, reset tile row
START_C, 3, reset tile column
HP_W, 5, HP register width
HP_FULL, 5, reset HP (must be < 2^HP_W)
N_MON, 2, number of monster channels
DAMAGE, 1, HP lost per hitting monster
INVULN_CYCLES, 1024, invulnerable cycles after a hit (16-bit counter)

Ports:
clk_13  in  1  system clock, same domain as pb_debounce
rst  in  1  synchronous reset, active-low
up_pressed/down_pressed/left_pressed/right_pressed  in  1 each  debounced key levels
dest_type  in  3  map type at (dest_r, dest_c), combinational map lookup
dest_r, dest_c  out  10 each  probed tile
actor_r, actor_c  out  10 each  logical tile position
actor_v, actor_h  out  10 each  sprite top-left in VGA pixels
facing  out  3  MOVE_DOWN/UP/LEFT/RIGHT encoding (1..4)
frame  out  2  0 idle, 1/2 walk frames
moving  out  1  high while a step animates
mon_r, mon_c  in  10*N_MON each  packed monster tiles, channel i at [10i+9:10i]
mon_alive  in  N_MON  per-channel alive
hp  out  HP_W  current HP
alive  out  1  hp != 0
hit  out  1  one-cycle pulse on the cycle HP decreases
invuln  out  1  invulnerability window active

Behaviour:
- All state is updated on posedge clk_13. When rst==0 at an edge, the following reset values load:
  - actor_r=START_R, actor_c=START_C.
  - actor_v=START_R<<TILE_LOG, actor_h=START_C<<TILE_LOG.
  - state=STOP, facing=DOWN(1), frame=0, moving=0.
  - hp=HP_FULL, hit=0, invuln=0, step counters=0.
  - Monster previous-position regs load the current mon_r/mon_c, so reset causes no spurious hit.
- Reset mid-step aborts the step immediately; no partial pixel offset is kept.
- States: STOP, UP, DOWN, LEFT, RIGHT (3-bit, same codes as MOVE_*).
- STOP with alive=1:
  - Key priority is up>down>left>right.
  - dest_r/dest_c = actor tile ±1 in the selected direction; otherwise dest = actor tile. Pure combinational.
  - Valid dest_type is 000, 001 or 011. Wall (010) and 1xx are blocked.
  - Valid: next cycle actor_r/c=dest, state=direction, facing=direction, moving=1, sub_cnt=0, pix_cnt=0.
  - Blocked: facing updates, state stays STOP, position unchanged.
  - Row/column arithmetic wraps mod 1024. Map bounds are enforced only through dest_type.
- Moving states:
  - Keys are ignored.
  - sub_cnt (WALK_DELAY bits) increments every cycle.
  - When sub_cnt is all-ones, actor_v/h steps 1 pixel toward the destination and pix_cnt increments.
  - When pix_cnt reaches 2^TILE_LOG-1 together with the sub_cnt all-ones cycle, state becomes STOP and moving=0 next cycle.
  - A step lasts exactly 2^(TILE_LOG+WALK_DELAY) cycles (1024 at defaults).
  - After the step, actor_v==actor_r<<TILE_LOG and actor_h==actor_c<<TILE_LOG.
- frame: 0 in STOP; 1 while pix_cnt < 2^(TILE_LOG-1); 2 otherwise.
- Damage:
  - Channel i qualifies when all hold: mon_alive[i]; its position differs from its previous-cycle value; its new position equals {actor_r, actor_c}.
  - dmg = DAMAGE * popcount(qualifiers), computed HP_W+4 bits wide.
  - If alive, not invuln, and dmg != 0: hp <= (dmg >= hp) ? 0 : hp-dmg; hit pulses high for 1 cycle.
  - Simultaneous hits from several channels sum in one cycle.
  - Actor movement itself never causes damage; only monster movement does.
- On alive=0:
  - FSM is forced to STOP and keys are ignored.
  - An in-progress step is frozen: the pixel position stays put and moving=0.
  - hp stays 0 until reset.

Optional Feature:
Macro ACTOR_INVULN_EN.
- Defined:
  - A hit loads invuln_cnt=INVULN_CYCLES-1 and sets invuln=1 next cycle.
  - While invuln=1, invuln_cnt decrements each cycle and damage is discarded; qualifying events are not queued.
  - invuln clears the cycle after invuln_cnt reaches 0.
- Undefined: invuln is tied to 0, no counter exists, and every qualifying event damages.

Test Plan:
1. Release rst; hold right_pressed 1 cycle with dest_type=000 -> actor_c=4 next cycle; moving=1 for 1024 cycles; actor_h 96->128 in 32 steps, one every 32 cycles; frame=1 for the first 512 cycles, then 2; then STOP, frame=0.
2. From reset, up_pressed with dest_type=010 -> dest_r=2, dest_c=3; actor_r stays 3, facing=2, moving=0; then down+left pressed together -> DOWN wins, dest_r=4.
3. Monster 0 moves from (3,2) to (3,3) at the actor -> hp 5->4, hit=1 for exactly 1 cycle. Monster 1 sits at (3,3) without moving -> no damage.
4. Both monsters step onto the actor in the same cycle with HP=1 -> hp=0 (saturates, no wrap), alive=0; then keys pressed -> no movement.
5. With ACTOR_INVULN_EN and INVULN_CYCLES=8: hit, then a second qualifying hit 4 cycles later -> ignored; a hit 9 cycles later -> hp decrements. Without the macro, both later hits decrement.
6. Assert rst=0 midway through a LEFT step -> next cycle actor_r/c=(3,3), actor_h=96, state STOP, hp=5.
